// File: rtl/apb_timer_bank_if.sv
// APB slave bus bundle for apb_timer_bank: zero-wait-state handshake,
// read/write data and error response.
interface apb_timer_bank_if #(
    parameter int TIMER_BITS = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  sel;
    logic                  enable;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [TIMER_BITS-1:0] wdata;
    logic [TIMER_BITS-1:0] rdata;
    logic                  ready;
    logic                  slverr;

    modport master (
        output sel, enable, write, addr, wdata,
        input  rdata, ready, slverr
    );

    modport slave (
        input  sel, enable, write, addr, wdata,
        output rdata, ready, slverr
    );
endinterface

// File: rtl/apb_timer_bank.sv
// Bank of CHANNELS independent APB-programmable up-counters with pause/abort,
// periodic restart and per-channel IRQ. Optional prescaler: TIMER_PRESCALER_EN.
module apb_timer_bank #(
    parameter int CHANNELS   = 4,
    parameter int TIMER_BITS = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    apb_timer_bank_if.slave     bus,
    output logic [CHANNELS-1:0] irq
);
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_COMPLETE = 2'd2,
        ST_PAUSED   = 2'd3
    } state_t;

    localparam int          TB  = TIMER_BITS;
    localparam logic [31:0] NCH = CHANNELS;

    logic          access_s;
    logic          wr_s;
    logic          rd_s;
    logic          err_s;
    logic          off3_err_s;
    logic [1:0]    off_s;
    logic [31:0]   ch_num_s;
    logic [TB-1:0] rd_val_s;
    logic [TB-1:0] val_s;

    logic          ctl_s;
    logic          stat_rd_s;
    logic          start_s;
    logic          stop_s;
    logic          tick_s;
    logic          done_s;
    logic          set_pend_s;
    logic [TB:0]   inc_s;

    state_t        state_r [CHANNELS];
    state_t        state_s [CHANNELS];
    logic [TB-1:0] goal_r  [CHANNELS];
    logic [TB-1:0] goal_s  [CHANNELS];
    logic [TB-1:0] curr_r  [CHANNELS];
    logic [TB-1:0] curr_s  [CHANNELS];
    logic [CHANNELS-1:0] periodic_r;
    logic [CHANNELS-1:0] periodic_s;
    logic [CHANNELS-1:0] irq_en_r;
    logic [CHANNELS-1:0] irq_en_s;
    logic [CHANNELS-1:0] pending_r;
    logic [CHANNELS-1:0] pending_s;
    logic [CHANNELS-1:0] irq_r;
    logic [CHANNELS-1:0] irq_s;
`ifdef TIMER_PRESCALER_EN
    logic [TB-1:0] presc_r [CHANNELS];
    logic [TB-1:0] presc_s [CHANNELS];
    logic [TB-1:0] pcnt_r  [CHANNELS];
    logic [TB-1:0] pcnt_s  [CHANNELS];
`endif

    // Address decode and error classification of the current access phase
    always_comb begin
        access_s = bus.sel & bus.enable;
        off_s    = bus.addr[1:0];
        ch_num_s = 32'(bus.addr[ADDR_WIDTH-1:2]);
`ifdef TIMER_PRESCALER_EN
        off3_err_s = 1'b0;
`else
        off3_err_s = (off_s == 2'd3);
`endif
        err_s = (ch_num_s >= NCH) | (bus.write & (off_s == 2'd2)) | off3_err_s;
        wr_s  = access_s & bus.write & ~err_s;
        rd_s  = access_s & ~bus.write & ~err_s;
    end

    // Read-data mux over the addressed channel
    always_comb begin
        rd_val_s = '0;
        val_s    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            case (off_s)
                2'd0:    val_s = TB'({1'b0, pending_r[i], irq_en_r[i], periodic_r[i],
                                      state_r[i], 2'b00});
                2'd1:    val_s = goal_r[i];
                2'd2:    val_s = curr_r[i];
`ifdef TIMER_PRESCALER_EN
                2'd3:    val_s = presc_r[i];
`else
                2'd3:    val_s = '0;
`endif
                default: val_s = '0;
            endcase
            rd_val_s = rd_val_s | ((ch_num_s == i) ? val_s : '0);
        end
    end

    // Zero-wait-state response; data is forced to 0 outside a clean access
    always_comb begin
        bus.ready  = access_s;
        bus.slverr = access_s & err_s;
        if (access_s && !err_s) begin
            bus.rdata = rd_val_s;
        end else begin
            bus.rdata = '0;
        end
    end

    // Per-channel control decode, counting and completion next-state
    always_comb begin
        ctl_s      = 1'b0;
        stat_rd_s  = 1'b0;
        start_s    = 1'b0;
        stop_s     = 1'b0;
        tick_s     = 1'b0;
        done_s     = 1'b0;
        set_pend_s = 1'b0;
        inc_s      = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_s[i]    = state_r[i];
            goal_s[i]     = goal_r[i];
            curr_s[i]     = curr_r[i];
            periodic_s[i] = periodic_r[i];
            irq_en_s[i]   = irq_en_r[i];
`ifdef TIMER_PRESCALER_EN
            presc_s[i] = presc_r[i];
            pcnt_s[i]  = pcnt_r[i];
            tick_s     = (pcnt_r[i] == presc_r[i]);
`else
            tick_s     = 1'b1;
`endif
            ctl_s      = wr_s & (ch_num_s == i) & (off_s == 2'd0);
            stat_rd_s  = rd_s & (ch_num_s == i) & (off_s == 2'd0);
            start_s    = ctl_s & bus.wdata[0];
            stop_s     = ctl_s & bus.wdata[1];
            inc_s      = {1'b0, curr_r[i]} + {{TB{1'b0}}, 1'b1};
            // Compare one bit wider so a saturated CURR still completes instead of wrapping
            done_s     = (inc_s >= {1'b0, goal_r[i]});
            set_pend_s = 1'b0;

            case (state_r[i])
                ST_IDLE, ST_COMPLETE: begin
                    if (start_s && !stop_s) begin
                        state_s[i] = ST_RUNNING;
                        curr_s[i]  = '0;
`ifdef TIMER_PRESCALER_EN
                        pcnt_s[i]  = '0;
`endif
                    end else if (stat_rd_s && (state_r[i] == ST_COMPLETE)) begin
                        state_s[i] = ST_IDLE;
                    end else begin
                        state_s[i] = state_r[i];
                    end
                end
                ST_PAUSED: begin
                    if (stop_s) begin
                        state_s[i] = ST_IDLE;
                        curr_s[i]  = '0;
                    end else if (start_s) begin
                        state_s[i] = ST_RUNNING;
                    end else begin
                        state_s[i] = ST_PAUSED;
                    end
                end
                ST_RUNNING: begin
                    // A STOP on the same edge as a tick swallows that tick
                    if (stop_s) begin
                        state_s[i] = ST_PAUSED;
                    end else if (tick_s) begin
`ifdef TIMER_PRESCALER_EN
                        pcnt_s[i] = '0;
`endif
                        if (done_s) begin
                            set_pend_s = 1'b1;
                            if (periodic_r[i]) begin
                                curr_s[i] = '0;
                            end else begin
                                state_s[i] = ST_COMPLETE;
                                curr_s[i]  = goal_r[i];
                            end
                        end else begin
                            curr_s[i] = inc_s[TB-1:0];
                        end
                    end else begin
`ifdef TIMER_PRESCALER_EN
                        pcnt_s[i] = pcnt_r[i] + TB'(1);
`endif
                        curr_s[i] = curr_r[i];
                    end
                end
                default: begin
                    state_s[i] = ST_IDLE;
                end
            endcase

            if (ctl_s) begin
                periodic_s[i] = bus.wdata[4];
                irq_en_s[i]   = bus.wdata[5];
            end else begin
                periodic_s[i] = periodic_r[i];
                irq_en_s[i]   = irq_en_r[i];
            end
            if (wr_s && (ch_num_s == i) && (off_s == 2'd1)) begin
                goal_s[i] = bus.wdata;
            end else begin
                goal_s[i] = goal_r[i];
            end
`ifdef TIMER_PRESCALER_EN
            if (wr_s && (ch_num_s == i) && (off_s == 2'd3)) begin
                presc_s[i] = bus.wdata;
            end else begin
                presc_s[i] = presc_r[i];
            end
`endif
            // A completion on the clearing edge keeps PENDING set
            pending_s[i] = (pending_r[i] & ~(ctl_s & bus.wdata[6])) | set_pend_s;
            irq_s[i]     = pending_s[i] & irq_en_s[i];
        end
    end

    // Channel registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_r[i] <= ST_IDLE;
                goal_r[i]  <= '0;
                curr_r[i]  <= '0;
`ifdef TIMER_PRESCALER_EN
                presc_r[i] <= '0;
                pcnt_r[i]  <= '0;
`endif
            end
            periodic_r <= '0;
            irq_en_r   <= '0;
            pending_r  <= '0;
            irq_r      <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_r[i] <= state_s[i];
                goal_r[i]  <= goal_s[i];
                curr_r[i]  <= curr_s[i];
`ifdef TIMER_PRESCALER_EN
                presc_r[i] <= presc_s[i];
                pcnt_r[i]  <= pcnt_s[i];
`endif
            end
            periodic_r <= periodic_s;
            irq_en_r   <= irq_en_s;
            pending_r  <= pending_s;
            irq_r      <= irq_s;
        end
    end

    assign irq = irq_r;
endmodule
